mig_app_responder: RTL and testbench

Synthesizable stand-in for the MIG 7-series DDR3 user interface: it is the responder end of the app_* command/write-data/read-data protocol that the memory adapter drives. It holds a small on-chip line store, so the adapter and mux can run in simulation and on FPGA bring-up without DDR3 or calibration hardware. It sits where the `sdram` MIG instance normally sits and reproduces its handshake rules, ordering and byte-mask semantics.

---
 rtl/gba_io_mem_pkg.sv | 14 +
 rtl/app_fifo.sv | 45 ++++
 rtl/mig_app_responder.sv | 137 +++++++++++++
 tb/tb_mig_app_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gba_io_mem_pkg.sv
// rtl/gba_io_mem_pkg.sv - app command codes and data-width encodings shared with the memory adapter
package gba_io_mem_pkg;

    typedef logic [2:0] app_cmd_t;

    localparam app_cmd_t APP_CMD_WRITE = 3'b000;
    localparam app_cmd_t APP_CMD_READ  = 3'b001;

    localparam logic [1:0] DATA_WIDTH_0  = 2'd0;
    localparam logic [1:0] DATA_WIDTH_8  = 2'd1;
    localparam logic [1:0] DATA_WIDTH_16 = 2'd2;
    localparam logic [1:0] DATA_WIDTH_32 = 2'd3;

endpackage

// File: rtl/app_fifo.sv
// rtl/app_fifo.sv - synchronous first-word-fall-through FIFO, DEPTH a power of two
module app_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mig_app_responder.sv
// rtl/mig_app_responder.sv - MIG app_* responder with on-chip line store; MIG_APP_RESPONDER_BACKPRESSURE_EN adds LFSR stalls
module mig_app_responder
    import gba_io_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 29,
    parameter int APP_DATA_WIDTH = 128,
    parameter int DEPTH_LOG2     = 10,
    parameter int RD_LATENCY     = 4,
    parameter int QUEUE_DEPTH    = 4,
    parameter int CALIB_CYCLES   = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_WIDTH-1:0]       app_addr,
    input  app_cmd_t                    app_cmd,
    input  logic                        app_en,
    output logic                        app_rdy,
    input  logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                        app_wdf_wren,
    input  logic                        app_wdf_end,
    output logic                        app_wdf_rdy,
    output logic [APP_DATA_WIDTH-1:0]   app_rd_data,
    output logic                        app_rd_data_valid,
    output logic                        app_rd_data_end,
    output logic                        init_calib_complete
);
    localparam int MASK_W = APP_DATA_WIDTH / 8;
    localparam int CMD_W  = 3 + DEPTH_LOG2;
    localparam int WDF_W  = APP_DATA_WIDTH + MASK_W;
    localparam int CW     = $clog2(CALIB_CYCLES + 1);
    localparam int OW     = $clog2(QUEUE_DEPTH + 1);

    logic                      calib;
    logic [CW-1:0]             calib_cnt;
    logic [OW-1:0]             rd_outstanding;
    logic                      bp_cmd;
    logic                      bp_wdf;

    logic [CMD_W-1:0]          cmd_dout;
    logic                      cmd_full, cmd_empty, cmd_push, cmd_pop;
    logic [WDF_W-1:0]          wdf_dout;
    logic                      wdf_full, wdf_empty, wdf_push;
    app_cmd_t                  head_cmd;
    logic [DEPTH_LOG2-1:0]     head_idx;
    logic [APP_DATA_WIDTH-1:0] wdf_data;
    logic [MASK_W-1:0]         wdf_mask;
    logic                      do_write, do_read, rd_accept;

    logic [APP_DATA_WIDTH-1:0] store [2**DEPTH_LOG2];
    logic [APP_DATA_WIDTH-1:0] rd_raw;
    logic [RD_LATENCY-2:0]     vld_pipe;
    logic [APP_DATA_WIDTH-1:0] data_pipe [RD_LATENCY-2];
    logic                      unused_bits;

    assign unused_bits = ^{app_wdf_end, app_addr[3:0], app_addr[ADDR_WIDTH-1:DEPTH_LOG2+4]};

`ifdef MIG_APP_RESPONDER_BACKPRESSURE_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= 16'hACE1;
        else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign bp_cmd = lfsr[0];
    assign bp_wdf = lfsr[1];
`else
    assign bp_cmd = 1'b0;
    assign bp_wdf = 1'b0;
`endif

    assign head_cmd = app_cmd_t'(cmd_dout[CMD_W-1 -: 3]);
    assign head_idx = cmd_dout[DEPTH_LOG2-1:0];
    assign wdf_data = wdf_dout[WDF_W-1 -: APP_DATA_WIDTH];
    assign wdf_mask = wdf_dout[MASK_W-1:0];

    // A write at the head blocks everything behind it until its data shows up.
    assign do_write = ~cmd_empty & (head_cmd == APP_CMD_WRITE) & ~wdf_empty;
    assign do_read  = ~cmd_empty & (head_cmd == APP_CMD_READ);
    assign cmd_pop  = do_write | (~cmd_empty & (head_cmd != APP_CMD_WRITE));

    assign app_rdy     = calib & (~cmd_full | cmd_pop) & (rd_outstanding < OW'(QUEUE_DEPTH)) & ~bp_cmd;
    assign app_wdf_rdy = calib & (~wdf_full | do_write) & ~bp_wdf;
    assign cmd_push    = app_en & app_rdy;
    assign wdf_push    = app_wdf_wren & app_wdf_rdy;
    assign rd_accept   = cmd_push & (app_cmd == APP_CMD_READ);

    app_fifo #(.WIDTH(CMD_W), .DEPTH(QUEUE_DEPTH)) u_cmd_q (
        .clk(clk), .rst(rst), .push(cmd_push), .din({app_cmd, app_addr[4 +: DEPTH_LOG2]}),
        .pop(cmd_pop), .dout(cmd_dout), .full(cmd_full), .empty(cmd_empty)
    );

    app_fifo #(.WIDTH(WDF_W), .DEPTH(QUEUE_DEPTH)) u_wdf_q (
        .clk(clk), .rst(rst), .push(wdf_push), .din({app_wdf_data, app_wdf_mask}),
        .pop(do_write), .dout(wdf_dout), .full(wdf_full), .empty(wdf_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            calib          <= 1'b0;
            calib_cnt      <= '0;
            rd_outstanding <= '0;
        end else begin
            if (!calib) begin
                calib_cnt <= calib_cnt + 1'b1;
                if (calib_cnt == CW'(CALIB_CYCLES - 1)) calib <= 1'b1;
            end
            rd_outstanding <= rd_outstanding + OW'(rd_accept) - OW'(app_rd_data_valid);
        end
    end

    // Store is deliberately outside the reset domain so contents survive a reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!wdf_mask[b]) store[head_idx][8*b +: 8] <= wdf_data[8*b +: 8];
            end
        end
        if (do_read) rd_raw <= store[head_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            for (int k = 0; k < RD_LATENCY - 2; k++) data_pipe[k] <= '0;
        end else begin
            vld_pipe     <= {vld_pipe[RD_LATENCY-3:0], do_read};
            data_pipe[0] <= rd_raw;
            for (int k = 1; k < RD_LATENCY - 2; k++) data_pipe[k] <= data_pipe[k-1];
        end
    end

    assign app_rd_data         = data_pipe[RD_LATENCY-3];
    assign app_rd_data_valid   = vld_pipe[RD_LATENCY-2];
    assign app_rd_data_end     = app_rd_data_valid;
    assign init_calib_complete = calib;

endmodule

// File: tb/tb_mig_app_responder.sv
// tb/tb_mig_app_responder.sv - table-driven and scoreboard bench for mig_app_responder
module tb_mig_app_responder;
    import gba_io_mem_pkg::*;

    localparam int CALIB      = 64;
    localparam int RD_LAT     = 4;
    localparam logic [127:0] D1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D1B = 128'h00112233_44556677_8899AABB_CCDD00FF;
    localparam logic [127:0] D2  = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
    localparam logic [127:0] D3  = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [28:0]  app_addr = '0;
    app_cmd_t     app_cmd = 3'b000;
    logic         app_en = 1'b0;
    logic         app_rdy;
    logic [127:0] app_wdf_data = '0;
    logic [15:0]  app_wdf_mask = '0;
    logic         app_wdf_wren = 1'b0;
    logic         app_wdf_end = 1'b0;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         init_calib_complete;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_seen = 0;
    logic [127:0] exp_q [$];
    int vcyc_q [$];

    typedef struct {
        logic [2:0]   cmd;
        logic [28:0]  addr;
        logic [127:0] data;
        logic [15:0]  mask;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [13];

    mig_app_responder dut (
        .clk(clk), .rst(rst), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end), .init_calib_complete(init_calib_complete)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (app_rd_data_valid) begin
            vcyc_q.push_back(cyc);
            valid_seen++;
            checks++;
            if (app_rd_data_end !== 1'b1) begin
                errors++;
                $display("FAIL rd_data_end got=%b want=1", app_rd_data_end);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rd_data got=%h want=none", app_rd_data);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (app_rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data got=%h want=%h", app_rd_data, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic send(input logic [2:0] c, input logic [28:0] a, input bit do_cmd,
                        input bit do_wdf, input logic [127:0] d, input logic [15:0] m,
                        output int acc);
        bit cmd_p = do_cmd;
        bit wdf_p = do_wdf;
        int guard = 0;
        acc = -1;
        while (cmd_p || wdf_p) begin
            app_en = cmd_p; app_cmd = c; app_addr = a;
            app_wdf_wren = wdf_p; app_wdf_end = wdf_p; app_wdf_data = d; app_wdf_mask = m;
            @(negedge clk);
            if (cmd_p && app_rdy) begin cmd_p = 0; acc = cyc; end
            if (wdf_p && app_wdf_rdy) begin wdf_p = 0; acc = cyc; end
            @(posedge clk); #1;
            guard++;
            if (guard > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout got=stalled want=accepted");
                break;
            end
        end
        app_en = 0; app_wdf_wren = 0; app_wdf_end = 0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_calib();
        int guard = 0;
        while (!init_calib_complete && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("calib_wait", init_calib_complete, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc, t0, low_cnt, vs;
        bit wdf_early;

        vecs[0]  = '{APP_CMD_WRITE, 29'h40,   D1,       16'h0000, '0};
        vecs[1]  = '{APP_CMD_WRITE, 29'h40,   {16{8'hFF}}, 16'hFFFE, '0};
        vecs[2]  = '{APP_CMD_READ,  29'h40,   '0,       16'h0000, D1};
        vecs[3]  = '{APP_CMD_WRITE, 29'h50,   D1,       16'h0000, '0};
        vecs[4]  = '{APP_CMD_WRITE, 29'h50,   '0,       16'hFFFD, '0};
        vecs[5]  = '{APP_CMD_READ,  29'h50,   '0,       16'h0000, D1B};
        vecs[6]  = '{APP_CMD_WRITE, 29'h4000, D2,       16'h0000, '0};
        vecs[7]  = '{APP_CMD_READ,  29'h0,    '0,       16'h0000, D2};
        vecs[8]  = '{APP_CMD_READ,  29'h4,    '0,       16'h0000, D2};
        vecs[9]  = '{APP_CMD_READ,  29'h40,   '0,       16'h0000, D1};
        vecs[10] = '{APP_CMD_READ,  29'h4050, '0,       16'h0000, D1B};
        vecs[11] = '{3'b111,        29'h40,   '0,       16'h0000, '0};
        vecs[12] = '{APP_CMD_READ,  29'h40,   '0,       16'h0000, D1};

        // Reset values and calibration window with app_en held high.
        app_en = 1; app_cmd = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_app_rdy", app_rdy, 1'b0);
        check("rst_wdf_rdy", app_wdf_rdy, 1'b0);
        check("rst_rd_data", app_rd_data, '0);
        check("rst_rd_valid", app_rd_data_valid, 1'b0);
        check("rst_rd_end", app_rd_data_end, 1'b0);
        check("rst_calib", init_calib_complete, 1'b0);
        @(posedge clk); #1;
        rst = 1;
        low_cnt = 0; wdf_early = 0;
        @(negedge clk);
        while (!app_rdy && low_cnt < 300) begin
            if (app_wdf_rdy) wdf_early = 1;
            low_cnt++;
            @(negedge clk);
        end
        check("calib_window", low_cnt, CALIB);
        check("calib_with_rdy", init_calib_complete, 1'b1);
        check("wdf_rdy_before_calib", wdf_early, 1'b0);
        @(posedge clk); #1;
        app_en = 0;
        repeat (2) @(posedge clk); #1;

        // Table of writes/reads; reads push their expected line to the scoreboard.
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].cmd == APP_CMD_READ) exp_q.push_back(vecs[i].exp);
            send(vecs[i].cmd, vecs[i].addr, 1, vecs[i].cmd == APP_CMD_WRITE,
                 vecs[i].data, vecs[i].mask, acc);
        end
        drain();

        // Single read latency, then four back-to-back reads.
        vcyc_q.delete();
        exp_q.push_back(D1);
        send(APP_CMD_READ, 29'h40, 1, 0, '0, '0, t0);
        drain();
        check("rd_latency", vcyc_q.size() > 0 ? vcyc_q[0] : -1, t0 + RD_LAT);
        vcyc_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(i[0] ? D1 : D2);
            send(APP_CMD_READ, i[0] ? 29'h40 : 29'h0, 1, 0, '0, '0, acc);
            if (i == 0) t0 = acc;
        end
        drain();
        check("b2b_count", vcyc_q.size(), 4);
        if (vcyc_q.size() == 4) begin
            check("b2b_first", vcyc_q[0], t0 + RD_LAT);
            for (int i = 1; i < 4; i++) check("b2b_consecutive", vcyc_q[i], vcyc_q[i-1] + 1);
        end

        // Write command first, read right behind it, data three cycles later.
        vcyc_q.delete();
        send(APP_CMD_WRITE, 29'h80, 1, 0, '0, '0, acc);
        exp_q.push_back(D3);
        send(APP_CMD_READ, 29'h80, 1, 0, '0, '0, acc);
        @(posedge clk); #1;
        send(APP_CMD_WRITE, 29'h0, 0, 1, D3, 16'h0000, t0);
        drain();
        check("late_wdf_rd_cycle", vcyc_q.size() > 0 ? vcyc_q[0] : -1, t0 + RD_LAT + 1);

        // Full command queue with write data withheld.
        for (int i = 0; i < 4; i++) send(APP_CMD_WRITE, 29'h100 + 29'(i * 16), 1, 0, '0, '0, acc);
        app_en = 1; app_cmd = APP_CMD_WRITE; app_addr = 29'h140;
        @(negedge clk);
        check("full_rdy_low", app_rdy, 1'b0);
        @(posedge clk); #1;
        app_wdf_wren = 1; app_wdf_end = 1; app_wdf_data = {4{32'hC0DE0000}}; app_wdf_mask = '0;
        @(negedge clk);
        check("full_wdf_rdy", app_wdf_rdy, 1'b1);
        check("full_rdy_still_low", app_rdy, 1'b0);
        @(posedge clk); #1;
        app_wdf_wren = 0; app_wdf_end = 0;
        @(negedge clk);
        check("full_recover", app_rdy, 1'b1);
        @(posedge clk); #1;
        app_en = 0;
        for (int i = 1; i < 5; i++) send(APP_CMD_WRITE, '0, 0, 1, {4{32'hC0DE0000 + 32'(i)}}, '0, acc);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({4{32'hC0DE0000 + 32'(i)}});
            send(APP_CMD_READ, 29'h100 + 29'(i * 16), 1, 0, '0, '0, acc);
        end
        drain();

        // Reset one cycle after a read accept drops the read but keeps the store.
        send(APP_CMD_READ, 29'h40, 1, 0, '0, '0, acc);
        vs = valid_seen;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        wait_calib();
        check("reset_drops_read", valid_seen, vs);
        exp_q.push_back(D1);
        send(APP_CMD_READ, 29'h40, 1, 0, '0, '0, acc);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
